// File: rtl/conv_flatten_streamer_if.sv
// Output stream bundle of conv_flatten_streamer: one element per valid/ready handshake,
// tagged with its source index and an end-of-frame marker.
interface conv_flatten_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IW         = 9
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [IW-1:0]         out_index;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/conv_flatten_streamer.sv
// Captures the flat pooled conv vector on start and streams it element by element into the FC stage.
// Optional macro FLATTEN_RELU_EN: zero negative elements (including -0) at the output mux.
module conv_flatten_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int MvgP3out   = 3,
    parameter int DepthC3    = 32,
    parameter int ORDER      = 0,
    localparam int S         = MvgP3out * MvgP3out,
    localparam int N         = S * DepthC3,
    localparam int IW        = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N*DATA_WIDTH-1:0] conv_in,
    conv_flatten_streamer_if.master m,
    output logic                    busy,
    output logic                    done,
    output logic                    err_overrun
);
    localparam int SW = $clog2(S + 1);
    localparam int CW = $clog2(DepthC3 + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [N*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           k_q, k_d;
    logic [SW-1:0]           s_q, s_d;
    logic [CW-1:0]           c_q, c_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;

    logic [IW-1:0] k_nxt;
    logic [SW-1:0] s_nxt;
    logic [CW-1:0] c_nxt;
    logic          hs;
    logic          at_last;

    // Spatial-major order keeps k as a running sum so the handshake path has no multiplier.
    always_comb begin
        k_nxt = k_q + IW'(1);
        s_nxt = s_q;
        c_nxt = c_q;
        if (ORDER != 0) begin
            if (c_q == CW'(DepthC3 - 1)) begin
                c_nxt = '0;
                s_nxt = s_q + SW'(1);
                k_nxt = IW'(s_q) + IW'(1);
            end else begin
                c_nxt = c_q + CW'(1);
                k_nxt = k_q + IW'(S);
            end
        end
    end

    assign hs      = (state_q == ST_STREAM) && m.out_ready;
    assign at_last = (ptr_q == IW'(N - 1));

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        ptr_d   = ptr_q;
        k_d     = k_q;
        s_d     = s_q;
        c_d     = c_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    buf_d   = conv_in;
                    ptr_d   = '0;
                    k_d     = '0;
                    s_d     = '0;
                    c_d     = '0;
                    data_d  = conv_in[0 +: DATA_WIDTH];
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A start during the final handshake still counts as an overrun.
                if (start) begin
                    err_d = 1'b1;
                end
                if (hs) begin
                    if (at_last) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d  = ptr_q + IW'(1);
                        k_d    = k_nxt;
                        s_d    = s_nxt;
                        c_d    = c_nxt;
                        data_d = buf_q[int'(k_nxt) * DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            ptr_q   <= '0;
            k_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            ptr_q   <= ptr_d;
            k_q     <= k_d;
            s_q     <= s_d;
            c_q     <= c_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign m.out_valid = (state_q == ST_STREAM);
    assign m.out_last  = (state_q == ST_STREAM) && at_last;
    assign m.out_index = k_q;
`ifdef FLATTEN_RELU_EN
    assign m.out_data  = data_q[DATA_WIDTH-1] ? '0 : data_q;
`else
    assign m.out_data  = data_q;
`endif

    assign busy        = (state_q == ST_STREAM);
    assign done        = (state_q == ST_DONE);
    assign err_overrun = err_q;
endmodule

// File: tb/tb_conv_flatten_streamer.sv
// Scoreboard bench: two instances (natural and spatial-major order) share clk/reset/start/conv_in;
// stimulus pushes expected beats, per-instance monitors pop and compare on every valid cycle.
module tb_conv_flatten_streamer;
    localparam int DW = 16;
    localparam int S  = 9;
    localparam int D  = 32;
    localparam int N  = 288;
    localparam int IW = 9;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [N*DW-1:0] conv_in = '0;
    logic [DW-1:0]   elem [N];
    logic            rdy [2];
    logic            busy [2];
    logic            done [2];
    logic            err [2];
    bit              rand_rdy = 1'b0;

    beat_t exp_q [2][$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rdy[0] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        rdy[1] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        conv_flatten_streamer_if #(.DATA_WIDTH(DW), .IW(IW)) sif ();
        assign sif.out_ready = rdy[gi];

        conv_flatten_streamer #(
            .DATA_WIDTH(DW), .MvgP3out(3), .DepthC3(D), .ORDER(gi)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .conv_in    (conv_in),
            .m          (sif),
            .busy       (busy[gi]),
            .done       (done[gi]),
            .err_overrun(err[gi])
        );

        bit    last_hs = 1'b0;
        beat_t got;
        beat_t want;

        always @(negedge clk) begin
            if (reset) begin
                last_hs = 1'b0;
            end else begin
                if (last_hs || done[gi]) begin
                    checks++;
                    if (done[gi] !== last_hs || (last_hs && (sif.out_valid || busy[gi]))) begin
                        errors++;
                        $display("FAIL done_pulse dut%0d: done=%0b valid=%0b busy=%0b, required done=%0b valid=0 busy=0",
                                 gi, done[gi], sif.out_valid, busy[gi], last_hs);
                    end
                end
                last_hs = 1'b0;
                if (sif.out_valid) begin
                    checks++;
                    got = {sif.out_data, sif.out_index, sif.out_last};
                    if (exp_q[gi].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat dut%0d: data=%h idx=%0d last=%0b, required no beat",
                                 gi, got.data, got.idx, got.last);
                    end else begin
                        want = exp_q[gi][0];
                        if (got !== want) begin
                            errors++;
                            $display("FAIL beat dut%0d: data=%h idx=%0d last=%0b, required data=%h idx=%0d last=%0b",
                                     gi, got.data, got.idx, got.last, want.data, want.idx, want.last);
                        end
                        if (sif.out_ready) begin
                            void'(exp_q[gi].pop_front());
                            last_hs = got.last;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef FLATTEN_RELU_EN
        return x[DW-1] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input bit relu_pat);
        for (int k = 0; k < N; k++) elem[k] = 16'h3C00 + 16'(k);
        if (relu_pat) begin
            elem[5] = 16'hBC00;
            elem[6] = 16'h8000;
            elem[7] = 16'h3C07;
        end
        for (int k = 0; k < N; k++) conv_in[k*DW +: DW] = elem[k];
    endtask

    task automatic push_expected();
        int k;
        for (int j = 0; j < N; j++) begin
            exp_q[0].push_back({relu(elem[j]), IW'(j), j == N - 1});
            k = (j % D) * S + (j / D);
            exp_q[1].push_back({relu(elem[k]), IW'(k), j == N - 1});
        end
    endtask

    task automatic issue_start(input bit with_expect);
        if (with_expect) push_expected();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy[0] || busy[1]) && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL timeout_%s: pending %0d/%0d beats, required 0", tag, exp_q[0].size(), exp_q[1].size());
        end
        cycles(3);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid0"}, 32'(g_dut[0].sif.out_valid), 0);
        chk({tag, "_valid1"}, 32'(g_dut[1].sif.out_valid), 0);
        chk({tag, "_data0"},  32'(g_dut[0].sif.out_data), 0);
        chk({tag, "_index1"}, 32'(g_dut[1].sif.out_index), 0);
        chk({tag, "_last0"},  32'(g_dut[0].sif.out_last), 0);
        chk({tag, "_busy"},   32'({busy[0], busy[1]}), 0);
        chk({tag, "_done"},   32'({done[0], done[1]}), 0);
        chk({tag, "_err"},    32'({err[0], err[1]}), 0);
    endtask

    initial begin
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        set_frame(1'b0);
        #3;
        check_outputs_zero("reset");
        cycles(2);
        reset = 1'b0;
        cycles(1);

        // Frame A: ready=1; conv_in scrambled after capture; start during DONE is ignored.
        issue_start(1'b1);
        conv_in = '0;
        cycles(288);
        chk("doneA", 32'({done[0], done[1]}), 32'h3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("A");
        chk("err_after_done_start", 32'({err[0], err[1]}), 0);

        // Frame B: random backpressure.
        set_frame(1'b0);
        rand_rdy = 1'b1;
        issue_start(1'b1);
        wait_idle("B");
        rand_rdy = 1'b0;

        // Reset mid-frame: outputs drop immediately, frame discarded, no done pulse.
        issue_start(1'b1);
        cycles(10);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_q[0].delete();
        exp_q[1].delete();
        cycles(2);
        reset = 1'b0;
        cycles(3);
        chk("post_reset_busy", 32'({busy[0], busy[1]}), 0);

        // Frame C: start coincides with the final handshake -> overrun, no new frame.
        issue_start(1'b1);
        cycles(287);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("C");
        chk("err_final_hs", 32'({err[0], err[1]}), 32'h3);

        // Frame D: start mid-stream with backpressure; stream unaltered, error stays sticky.
        rand_rdy = 1'b1;
        issue_start(1'b1);
        cycles(120);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("D");
        rand_rdy = 1'b0;
        chk("err_sticky", 32'({err[0], err[1]}), 32'h3);

        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(1);
        chk("err_cleared", 32'({err[0], err[1]}), 0);

        // Frame E: negative / negative-zero / positive elements around index 5..7.
        set_frame(1'b1);
        issue_start(1'b1);
        wait_idle("E");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
